r5p_mouse_tcb_dec: RTL and testbench
====================================

Name: r5p_mouse_tcb_dec

Overview:
- 1-manager to SUB_N-subordinate TCL system-bus decoder with a fixed read-response delay.
- Sits directly downstream of the R5P Mouse core bus port. Splits the single shared fetch/GPR/load/store bus into GPR RAM, main memory and peripheral regions.
- Tracks outstanding responses and routes each subordinate's rdt/err back to the core DLY cycles after each transfer.
- Generates error responses for unmapped addresses and for subordinate stall timeouts.

Parameters:
- SUB_N, 3: number of subordinate ports (1..8).
- DLY, 1: read-response delay in cycles after a transfer (1..4). The same value applies to all subordinates.
- ADR_BAS, {32'h2000_0000, 32'h0000_0000, 32'h1000_0000}: per-subordinate base address (index 0 = GPR, 1 = memory, 2 = peripheral).
- ADR_MSK, {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_FF80}: per-subordinate compare mask.
- TMO, 16: number of consecutive stall cycles before an abort (2..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- man_vld  in  1  manager valid
- man_wen  in  1  manager write enable
- man_adr  in  32  manager address
- man_ben  in  4  manager byte enable
- man_wdt  in  32  manager write data
- man_rdt  out  32  manager read data
- man_err  out  1  manager error
- man_rdy  out  1  manager ready
- sub_vld  out  SUB_N  subordinate valid
- sub_wen  out  SUB_N  subordinate write enable
- sub_adr  out  SUB_N x 32  subordinate address
- sub_ben  out  SUB_N x 4  subordinate byte enable
- sub_wdt  out  SUB_N x 32  subordinate write data
- sub_rdt  in  SUB_N x 32  subordinate read data
- sub_err  in  SUB_N  subordinate error
- sub_rdy  in  SUB_N  subordinate ready

Behaviour:
- **Transfer rule:** a transfer occurs when vld & rdy in the same cycle. Read data/err for a transfer appears on man_rdt/man_err exactly DLY cycles later, for one cycle.
- **Decode (combinational):** hit[i] = ((man_adr & ADR_MSK[i]) == ADR_BAS[i]). On multiple hits, the lowest index wins.
- **Request forwarding:** wen/adr/ben/wdt are broadcast to all subordinates. sub_vld[i] = man_vld & sel[i] & ~tmo_abort.
- **Ready:**
  - hit: man_rdy = sub_rdy[sel] | tmo_abort.
  - no hit: man_rdy = 1 (local error transfer, no sub_vld asserted).
- **Timeout counter (8 bit):**
  - Increments while man_vld & hit & ~sub_rdy[sel].
  - Clears on any transfer, or when man_vld = 0.
  - tmo_abort = (cnt == TMO-1) & man_vld & ~sub_rdy[sel].
  - On the abort cycle, sub_vld is forced to 0 and man_rdy to 1. The abort counts as a transfer with a local error.
- **Response pipeline:** DLY stages of {act, loc_err, sel_idx}, reset to 0.
  - Stage 0 is loaded every cycle with {man_trn, ~hit | tmo_abort, enc(sel)}.
  - Output stage drives the manager:
    - act & loc_err: man_rdt = 0, man_err = 1.
    - act & ~loc_err: man_rdt = sub_rdt[idx], man_err = sub_err[idx].
    - ~act: man_rdt = 0, man_err = 0.
- **Back-to-back transfers:** transfers to different subordinates are allowed in consecutive cycles. Response order equals request order, with no bubbles.
- **Writes:** writes also occupy a pipeline slot. Their rdt is don't-care but still routed; err is routed.
- **Reset values:** pipeline act = 0, counter = 0. Outputs man_rdt = 0, man_err = 0. man_rdy and sub_* are combinational from inputs.
- **Reset mid-operation:** pending responses are discarded; no response is emitted after reset release.
- **man_vld dropped while stalled:** the counter clears and no transfer is recorded.

Optional Feature:
- Macro R5P_TCB_DEC_ERRLOG_EN.
- Enabled, adds ports:
  - err_vld  out  1: sticky.
  - err_adr  out  32.
  - err_typ  out  2: 01 = unmapped, 10 = timeout, 11 = subordinate err.
  - err_clr  in  1.
- Capture rules:
  - Captures the first error while err_vld = 0.
  - err_adr holds the manager address registered at transfer time and carried through the pipeline.
  - err_clr clears err_vld the next cycle. If clear and a new error coincide, the new error is captured.
  - Reset: all 0.
- Disabled: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- **Read GPR:** read 0x1000_0014, sub_rdy[0] = 1, sub_rdt[0] = 0xDEAD_BEEF one cycle later → sub_vld = 3'b001; cycle after transfer, man_rdt = 0xDEAD_BEEF, man_err = 0.
- **Unmapped read:** read 0x4000_0000 → man_rdy = 1 same cycle, no sub_vld; next cycle man_err = 1, man_rdt = 0 (errlog: err_typ = 01, err_adr = 0x4000_0000).
- **Back-to-back:** write 0x1000_0004 (wdt 0x1234_5678), read 0x0000_0100, read 0x2000_0008 in consecutive cycles with all rdy = 1 → sub_vld sequence 001, 010, 100; responses in order from sub1 then sub2, no gaps.
- **Stall then timeout:** sub_rdy[1] = 1 after 3 stall cycles → transfer in 4th cycle, counter clears. sub_rdy[1] held 0 → man_rdy = 1 on cycle 16, sub_vld[1] = 0 that cycle, man_err = 1 one cycle later.
- **DLY = 3, reset mid-flight:** two reads issued, rst pulsed before the responses → no man_err/man_rdt activity after release; a fresh read responds exactly 3 cycles after its transfer.
- **Subordinate error passthrough:** sub_err[2] = 1 on a peripheral read → man_err = 1 at DLY. Overlapping mask decode (address hitting both index 0 and 2 via custom params) → index 0 selected.

Source files
------------

// File: rtl/r5p_mouse_tcb_dec.sv
// r5p_mouse_tcb_dec: routes one TCB manager to SUB_N subordinates and returns responses DLY cycles after each transfer.
// Optional error log ports and logic are included when R5P_TCB_DEC_ERRLOG_EN is defined.
module r5p_mouse_tcb_dec #(
    parameter int unsigned              SUB_N   = 3,
    parameter int unsigned              DLY     = 1,
    parameter logic [SUB_N-1:0][31:0]   ADR_BAS = {32'h2000_0000, 32'h0000_0000, 32'h1000_0000},
    parameter logic [SUB_N-1:0][31:0]   ADR_MSK = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_FF80},
    parameter int unsigned              TMO     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        man_vld,
    input  logic                        man_wen,
    input  logic [31:0]                 man_adr,
    input  logic [3:0]                  man_ben,
    input  logic [31:0]                 man_wdt,
    output logic [31:0]                 man_rdt,
    output logic                        man_err,
    output logic                        man_rdy,
    output logic [SUB_N-1:0]            sub_vld,
    output logic [SUB_N-1:0]            sub_wen,
    output logic [SUB_N-1:0][31:0]      sub_adr,
    output logic [SUB_N-1:0][3:0]       sub_ben,
    output logic [SUB_N-1:0][31:0]      sub_wdt,
    input  logic [SUB_N-1:0][31:0]      sub_rdt,
    input  logic [SUB_N-1:0]            sub_err,
    input  logic [SUB_N-1:0]            sub_rdy
`ifdef R5P_TCB_DEC_ERRLOG_EN
    ,
    output logic                        err_vld,
    output logic [31:0]                 err_adr,
    output logic [1:0]                  err_typ,
    input  logic                        err_clr
`endif
);

    localparam int unsigned IW = (SUB_N > 1) ? $clog2(SUB_N) : 1;

    typedef struct packed {
        logic          act;
        logic          loc_err;
`ifdef R5P_TCB_DEC_ERRLOG_EN
        logic          tmo;
        logic [31:0]   adr;
`endif
        logic [IW-1:0] idx;
    } stage_t;

    logic               w_hit;
    logic [IW-1:0]      w_idx;
    logic [SUB_N-1:0]   w_sel;
    logic               w_stall;
    logic               w_abort;
    logic               w_trn;
    logic [7:0]         r_cnt;
    stage_t             w_stg_in;
    stage_t             w_out;
    stage_t             r_pipe [DLY];

    // Lowest matching index wins: scan downwards so the last assignment is the smallest hit.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_sel = '0;
        for (int i = SUB_N - 1; i >= 0; i--) begin
            if ((man_adr & ADR_MSK[i]) == ADR_BAS[i]) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
        if (w_hit) w_sel[w_idx] = 1'b1;
    end

    assign w_stall = man_vld & w_hit & ~sub_rdy[w_idx];
    assign w_abort = w_stall & (r_cnt == 8'(TMO - 1));
    assign man_rdy = ~w_hit | sub_rdy[w_idx] | w_abort;
    assign w_trn   = man_vld & man_rdy;
    assign sub_vld = {SUB_N{man_vld & ~w_abort}} & w_sel;

    always_comb begin
        for (int i = 0; i < SUB_N; i++) begin
            sub_wen[i] = man_wen;
            sub_adr[i] = man_adr;
            sub_ben[i] = man_ben;
            sub_wdt[i] = man_wdt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_trn || !man_vld) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_stg_in         = '0;
        w_stg_in.act     = w_trn;
        w_stg_in.loc_err = ~w_hit | w_abort;
        w_stg_in.idx     = w_idx;
`ifdef R5P_TCB_DEC_ERRLOG_EN
        w_stg_in.tmo     = w_abort;
        w_stg_in.adr     = man_adr;
`endif
    end

    // NOTE: the pipeline is only DLY entries, so it is reset in full; reset discards pending responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DLY; s++) r_pipe[s] <= '0;
        end else begin
            r_pipe[0] <= w_stg_in;
            for (int s = 1; s < DLY; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign w_out = r_pipe[DLY-1];

    always_comb begin
        man_rdt = '0;
        man_err = 1'b0;
        if (w_out.act) begin
            if (w_out.loc_err) begin
                man_err = 1'b1;
            end else begin
                man_rdt = sub_rdt[w_out.idx];
                man_err = sub_err[w_out.idx];
            end
        end
    end

`ifdef R5P_TCB_DEC_ERRLOG_EN
    logic        w_err_evt;
    logic [1:0]  w_err_typ;
    logic        r_err_vld;
    logic [31:0] r_err_adr;
    logic [1:0]  r_err_typ;

    assign w_err_evt = w_out.act & (w_out.loc_err | sub_err[w_out.idx]);
    assign w_err_typ = !w_out.loc_err ? 2'b11 : (w_out.tmo ? 2'b10 : 2'b01);

    // A clear coinciding with a new error lets the new error in rather than dropping it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_vld <= 1'b0;
            r_err_adr <= '0;
            r_err_typ <= '0;
        end else if (w_err_evt && (!r_err_vld || err_clr)) begin
            r_err_vld <= 1'b1;
            r_err_adr <= w_out.adr;
            r_err_typ <= w_err_typ;
        end else if (err_clr) begin
            r_err_vld <= 1'b0;
        end
    end

    assign err_vld = r_err_vld;
    assign err_adr = r_err_adr;
    assign err_typ = r_err_typ;
`endif

endmodule

// File: tb/tb_r5p_mouse_tcb_dec.sv
// Bench for r5p_mouse_tcb_dec: directed + randomized traffic checked by a response scoreboard,
// plus a DLY=3 instance with overlapping decode for latency and reset-in-flight behaviour.
`timescale 1ns/1ps
module tb_r5p_mouse_tcb_dec;

    localparam int N   = 3;
    localparam int DLY = 1;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    endtask

    // ---------------- main instance (default parameters) ----------------
    logic              man_vld = 0, man_wen = 0, man_rdy, man_err;
    logic [31:0]       man_adr = 0, man_wdt = 0, man_rdt;
    logic [3:0]        man_ben = 0;
    logic [N-1:0]      sub_vld, sub_wen, sub_err = 0, sub_rdy = 0;
    logic [N-1:0][31:0] sub_adr, sub_wdt, sub_rdt = 0;
    logic [N-1:0][3:0] sub_ben;

    r5p_mouse_tcb_dec dut (
        .clk(clk), .rst(rst),
        .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr), .man_ben(man_ben),
        .man_wdt(man_wdt), .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben),
        .sub_wdt(sub_wdt), .sub_rdt(sub_rdt), .sub_err(sub_err), .sub_rdy(sub_rdy)
    );

    typedef struct {
        int          due;
        bit          dc_rdt;
        logic [31:0] rdt;
        logic        err;
    } exp_t;

    typedef struct {
        int          idx;
        logic [31:0] rdt;
        logic        err;
    } sub_resp_t;

    exp_t        sbq[$];
    sub_resp_t   sub_sched [int];
    logic [31:0] mem [logic [33:0]];
    int          stall_run = 0;

    // Subordinate storage model: written words read back, untouched words return an address hash.
    function automatic logic [31:0] sub_data(input int i, input logic [31:0] a);
        logic [33:0] k;
        k = {2'(i), a};
        if (mem.exists(k)) return mem[k];
        return (a * 32'h9E37_79B9) ^ (32'(i) << 28);
    endfunction

    function automatic logic sub_errf(input logic [31:0] a);
        return a[11:8] == 4'hE;
    endfunction

    // One manager cycle. reg_id is the region the address was built for (-1 = unmapped).
    task automatic step(input bit vld, input bit wen, input logic [31:0] adr, input logic [3:0] ben,
                        input logic [31:0] wdt, input logic [N-1:0] rdy, input int reg_id, output bit trn);
        bit hit, sel_rdy, stall, abort, exp_rdy;
        logic [N-1:0] exp_vld;
        int k;
        logic [31:0] rd;
        logic e;
        @(negedge clk);
        man_vld = vld; man_wen = wen; man_adr = adr; man_ben = ben; man_wdt = wdt; sub_rdy = rdy;
        for (int i = 0; i < N; i++) begin
            sub_rdt[i] = $urandom;
            sub_err[i] = 1'($urandom_range(0, 1));
        end
        if (sub_sched.exists(cyc)) begin
            sub_rdt[sub_sched[cyc].idx] = sub_sched[cyc].rdt;
            sub_err[sub_sched[cyc].idx] = sub_sched[cyc].err;
            sub_sched.delete(cyc);
        end
        #1;
        hit     = reg_id >= 0;
        sel_rdy = 1'b1;
        if (hit) sel_rdy = rdy[reg_id];
        stall   = vld && hit && !sel_rdy;
        abort   = stall && (stall_run == TMO - 1);
        exp_rdy = !hit || sel_rdy || abort;
        trn     = vld && exp_rdy;
        exp_vld = '0;
        if (vld && hit && !abort) exp_vld[reg_id] = 1'b1;
        check("man_rdy", 96'(man_rdy), 96'(exp_rdy));
        check("sub_vld", 96'(sub_vld), 96'(exp_vld));
        k = cyc % N;
        check("broadcast", {sub_wen[k], sub_ben[k], sub_adr[k], sub_wdt[k]}, {wen, ben, adr, wdt});
        if (trn || !vld) stall_run = 0;
        else if (stall) stall_run++;
        if (trn) begin
            if (!hit || abort) begin
                sbq.push_back('{due: cyc + DLY, dc_rdt: 1'b0, rdt: 32'h0, err: 1'b1});
            end else begin
                rd = sub_data(reg_id, adr);
                e  = sub_errf(adr);
                if (wen) begin
                    mem[{2'(reg_id), adr}] = wdt;
                    rd = $urandom;
                end
                sub_sched[cyc + DLY] = '{idx: reg_id, rdt: rd, err: e};
                sbq.push_back('{due: cyc + DLY, dc_rdt: wen, rdt: rd, err: e});
            end
        end
    endtask

    task automatic idle(input int n);
        bit t;
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 4'h0, 32'h0, '1, -1, t);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) continue;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                check("resp_err", 96'(man_err), 96'(e.err));
                if (!e.dc_rdt) check("resp_rdt", 96'(man_rdt), 96'(e.rdt));
            end else begin
                check("resp_idle", {man_err, man_rdt}, 96'h0);
            end
        end
    end

    // ---------------- DLY=3 instance with overlapping decode (0x1000_00xx hits index 0 and 2) ----------------
    logic               m3_vld = 0, m3_rdy, m3_err, m3_wen = 0;
    logic [31:0]        m3_adr = 0, m3_rdt, m3_wdt = 0;
    logic [3:0]         m3_ben = 4'hF;
    logic [N-1:0]       s3_vld, s3_wen, s3_err = 0, s3_rdy = '1;
    logic [N-1:0][31:0] s3_adr, s3_wdt;
    logic [N-1:0][31:0] s3_rdt = {32'hC222_2222, 32'hC111_1111, 32'hC000_0000};
    logic [N-1:0][3:0]  s3_ben;

    r5p_mouse_tcb_dec #(
        .SUB_N(3), .DLY(3), .TMO(16),
        .ADR_BAS({32'h1000_0000, 32'h0000_0000, 32'h1000_0000}),
        .ADR_MSK({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00})
    ) dut3 (
        .clk(clk), .rst(rst3),
        .man_vld(m3_vld), .man_wen(m3_wen), .man_adr(m3_adr), .man_ben(m3_ben),
        .man_wdt(m3_wdt), .man_rdt(m3_rdt), .man_err(m3_err), .man_rdy(m3_rdy),
        .sub_vld(s3_vld), .sub_wen(s3_wen), .sub_adr(s3_adr), .sub_ben(s3_ben),
        .sub_wdt(s3_wdt), .sub_rdt(s3_rdt), .sub_err(s3_err), .sub_rdy(s3_rdy)
    );

    exp_t q3[$];

    task automatic step3(input bit vld, input logic [31:0] adr, input int idx);
        logic [N-1:0] ev;
        @(negedge clk);
        m3_vld = vld; m3_adr = adr;
        #1;
        ev = '0;
        if (vld) ev[idx] = 1'b1;
        check("d3_sub_vld", 96'(s3_vld), 96'(ev));
        if (vld) begin
            check("d3_rdy", 96'(m3_rdy), 96'h1);
            q3.push_back('{due: cyc + 3, dc_rdt: 1'b0, rdt: s3_rdt[idx], err: 1'b0});
        end
    endtask

    initial begin : monitor3
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst3) begin
                q3.delete();
                continue;
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                e = q3.pop_front();
                check("d3_resp", {m3_err, m3_rdt}, {e.err, e.rdt});
            end else begin
                check("d3_idle", {m3_err, m3_rdt}, 96'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        bit t;
        bit keep;
        int stuck;
        int rid;
        logic [31:0] a, w;
        logic [3:0] b;
        bit v, we;

        repeat (3) @(negedge clk);
        check("rst_outputs", {man_err, man_rdt, m3_err, m3_rdt}, 96'h0);
        rst = 1'b0;
        rst3 = 1'b0;
        idle(3);

        // Read the first subordinate; its word was preset.
        mem[{2'd0, 32'h1000_0014}] = 32'hDEAD_BEEF;
        step(1, 0, 32'h1000_0014, 4'hF, 32'h0, '1, 0, t);
        // Unmapped read.
        step(1, 0, 32'h4000_0000, 4'hF, 32'h0, '1, -1, t);
        // Back-to-back across all three subordinates.
        step(1, 1, 32'h1000_0004, 4'hF, 32'h1234_5678, '1, 0, t);
        step(1, 0, 32'h0000_0100, 4'hF, 32'h0, '1, 1, t);
        step(1, 0, 32'h2000_0008, 4'hF, 32'h0, '1, 2, t);
        step(1, 0, 32'h1000_0004, 4'hF, 32'h0, '1, 0, t);
        idle(2);
        // Stall three cycles then accept; then stall until the timeout aborts.
        repeat (3) step(1, 0, 32'h0000_0200, 4'hF, 32'h0, 3'b101, 1, t);
        step(1, 0, 32'h0000_0200, 4'hF, 32'h0, 3'b111, 1, t);
        repeat (TMO) step(1, 0, 32'h0000_0204, 4'hF, 32'h0, 3'b101, 1, t);
        idle(2);
        // Dropping valid mid-stall restarts the timeout.
        repeat (5) step(1, 0, 32'h2000_0010, 4'hF, 32'h0, 3'b011, 2, t);
        step(0, 0, 32'h2000_0010, 4'hF, 32'h0, 3'b011, 2, t);
        repeat (TMO) step(1, 0, 32'h2000_0010, 4'hF, 32'h0, 3'b011, 2, t);
        idle(2);
        // Subordinate error passthrough and decode boundaries.
        step(1, 0, 32'h2000_0E00, 4'hF, 32'h0, '1, 2, t);
        step(1, 0, 32'h1000_007C, 4'hF, 32'h0, '1, 0, t);
        step(1, 0, 32'h1000_0080, 4'hF, 32'h0, '1, -1, t);
        step(1, 0, 32'h0000_FFFC, 4'hF, 32'h0, '1, 1, t);
        step(1, 0, 32'h0001_0000, 4'hF, 32'h0, '1, -1, t);
        step(1, 0, 32'h2000_0FFC, 4'hF, 32'h0, '1, 2, t);
        step(1, 0, 32'h2000_1000, 4'hF, 32'h0, '1, -1, t);
        idle(2);

        // Randomized traffic with occasional long stalls.
        t = 1'b1; stuck = 0; rid = -1;
        v = 0; we = 0; a = 0; w = 0; b = 0;
        for (int n = 0; n < 3000; n++) begin
            keep = v && !t && ($urandom_range(0, 15) != 0);
            if (!keep) begin
                v  = $urandom_range(0, 3) != 0;
                we = 1'($urandom_range(0, 1));
                w  = $urandom;
                b  = 4'($urandom);
                case ($urandom_range(0, 3))
                    0: begin a = 32'h1000_0000 | ($urandom & 32'h7C);        rid = 0;  end
                    1: begin a = ($urandom & 32'hFFFC);                      rid = 1;  end
                    2: begin a = 32'h2000_0000 | ($urandom & 32'hFFC);       rid = 2;  end
                    default: begin a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC); rid = -1; end
                endcase
            end
            if (stuck == 0 && $urandom_range(0, 59) == 0) stuck = $urandom_range(10, 25);
            if (stuck > 0) begin
                stuck--;
                step(v, we, a, b, w, 3'b000, rid, t);
            end else begin
                step(v, we, a, b, w, N'($urandom_range(0, 7) | $urandom_range(0, 7)), rid, t);
            end
        end
        idle(4);
        check("drain", 96'(sbq.size()), 96'h0);

        // DLY=3 instance: overlap decode, reset with two reads in flight, then a fresh read.
        step3(1, 32'h1000_0010, 0);
        step3(1, 32'h1000_0400, 2);
        step3(0, 32'h0, 0);
        step3(0, 32'h0, 0);
        step3(0, 32'h0, 0);
        step3(1, 32'h1000_0010, 0);
        step3(1, 32'h1000_0400, 2);
        @(negedge clk);
        m3_vld = 1'b0;
        rst3 = 1'b1;
        q3.delete();
        @(negedge clk);
        rst3 = 1'b0;
        repeat (6) step3(0, 32'h0, 0);
        step3(1, 32'h0000_0040, 1);
        repeat (5) step3(0, 32'h0, 0);
        check("d3_drain", 96'(q3.size()), 96'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
